// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared types and helpers for the serial bit transmitter
package serial_tx_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;

    localparam logic IDLE_LEVEL_DEF = 1'b0;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, MSB-first shift register with serial fill
module piso_shift_reg #(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    input  logic         ser_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= (sr_q << 1) | W'(ser_i);
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - valid/ready parallel-to-serial transmitter, MSB first, idle gap after each frame
// Optional even-parity trailer bit enabled by SERIAL_TX_PARITY_EN.
module serial_bit_tx
    import serial_tx_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              d_out,
    output logic              busy,
    output logic              done
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int BW = cnt_w(DATA_W);
    localparam int GW = (GAP_CYCLES > 0) ? cnt_w(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    tx_state_t    state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic         d_out_q, d_out_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         sr_load, sr_shift, sr_msb, ser_fill;

`ifdef SERIAL_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (sr_load) begin
            parity_q <= ^data_in;
        end
    end

    // parity trails the data bits out of the shift register
    assign ser_fill = parity_q;
`else
    assign ser_fill = 1'b0;
`endif

    // the MSB goes straight to d_out on accept; the register holds the remaining bits
    piso_shift_reg #(.W(DATA_W - 1)) u_piso (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (data_in[DATA_W-2:0]),
        .ser_i   (ser_fill),
        .msb_o   (sr_msb)
    );

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        gcnt_d   = gcnt_q;
        d_out_d  = d_out_q;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        case (state_q)
            IDLE: begin
                d_out_d = IDLE_LEVEL;
                if (valid_in) begin
                    state_d = SHIFT;
                    bcnt_d  = BIT_LAST;
                    sr_load = 1'b1;
                    d_out_d = data_in[DATA_W-1];
                end
            end
            SHIFT: begin
                if (bcnt_q != '0) begin
                    sr_shift = 1'b1;
                    d_out_d  = sr_msb;
                    bcnt_d   = bcnt_q - 1'b1;
                    done_d   = (bcnt_q == BW'(1));
                    // without a gap, drop to IDLE while the last bit is on the line
                    if (bcnt_q == BW'(1) && GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = GAP;
                    gcnt_d  = GAP_LAST;
                    d_out_d = IDLE_LEVEL;
                end
            end
            GAP: begin
                d_out_d = IDLE_LEVEL;
                if (gcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                d_out_d = IDLE_LEVEL;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            d_out_q <= IDLE_LEVEL;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            d_out_q <= d_out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign ready_out = (state_q == IDLE);
    assign d_out     = d_out_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule
